// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO one word at a time and
// serializes each word as start, LSB-first data, optional parity, stop(s).
// Ports:
//   clk, rst_      clock; asynchronous active-low reset
//   en             transmit enable, sampled only while idle
//   fifo_empty     FIFO empty flag
//   fifo_dout      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en     one-cycle read strobe to the FIFO
//   tx             serial line, idle high, registered
//   busy           high whenever a frame is in progress
//   tx_done        registered pulse on the last cycle of the last stop bit
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [BW-1:0]         r_baud;
  logic [BW-1:0]         w_baud_n;
  logic [IW-1:0]         r_bit;
  logic [IW-1:0]         w_bit_n;
  logic                  r_stop;
  logic                  w_stop_n;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_n;
  logic                  r_parity;
  logic                  w_parity_n;
  logic                  r_tx;
  logic                  w_tx_n;
  logic                  r_done;
  logic                  w_done_n;
  logic                  w_baud_end;
  logic                  w_rd;

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_rd       = (r_state == S_IDLE) & en & ~fifo_empty;

  always_comb begin
    w_state_n  = r_state;
    w_baud_n   = r_baud;
    w_bit_n    = r_bit;
    w_stop_n   = r_stop;
    w_shreg_n  = r_shreg;
    w_parity_n = r_parity;
    unique case (r_state)
      S_IDLE: begin
        if (w_rd) w_state_n = S_LOAD;
      end
      S_LOAD: begin
        w_shreg_n  = fifo_dout;
        w_parity_n = ^fifo_dout ^ ODD;
        w_baud_n   = '0;
        w_bit_n    = '0;
        w_stop_n   = 1'b0;
        w_state_n  = S_START;
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_state_n = S_DATA;
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_shreg_n = r_shreg >> 1;
          if (r_bit == BIT_LAST) begin
            w_bit_n   = '0;
            w_state_n = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            w_bit_n = r_bit + IW'(1);
          end
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_state_n = S_STOP;
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_stop == STOP_LAST) begin
            w_stop_n  = 1'b0;
            w_state_n = S_IDLE;
          end else begin
            w_stop_n = 1'b1;
          end
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // tx is registered from the next-state view so the line
    // changes exactly on entry to each bit, with no extra lag.
    unique case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shreg_n[0];
      S_PARITY: w_tx_n = w_parity_n;
      default:  w_tx_n = 1'b1;
    endcase

    w_done_n = (w_state_n == S_STOP) &&
               (w_baud_n == BAUD_LAST) &&
               (w_stop_n == STOP_LAST);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_shreg  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_baud   <= w_baud_n;
      r_bit    <= w_bit_n;
      r_stop   <= w_stop_n;
      r_shreg  <= w_shreg_n;
      r_parity <= w_parity_n;
      r_tx     <= w_tx_n;
      r_done   <= w_done_n;
    end
  end

  assign fifo_rd_en = w_rd;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign tx_done    = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a small
// registered-read FIFO model and two parity/2-stop instances.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_;
  logic en;
  logic p_en;

  logic [7:0] mem [0:15];
  int         wr = 0;
  int         rd = 0;
  logic [7:0] f_dout = 8'h00;
  logic       f_empty;
  logic       rd_en, tx, busy, done;

  assign f_empty = (wr == rd);

  always @(posedge clk) begin
    if (rd_en) begin
      f_dout <= mem[rd[3:0]];
      rd     <= rd + 1;
    end
  end

  int         p_req = 0;
  int         pe_taken = 0;
  int         po_taken = 0;
  logic [7:0] p_dout;
  logic       pe_empty, po_empty;
  logic       pe_rd, pe_tx, pe_busy, pe_done;
  logic       po_rd, po_tx, po_busy, po_done;

  assign p_dout   = 8'h07;
  assign pe_empty = (p_req == pe_taken);
  assign po_empty = (p_req == po_taken);

  always @(posedge clk) begin
    if (pe_rd) pe_taken <= pe_taken + 1;
    if (po_rd) po_taken <= po_taken + 1;
  end

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut (
    .clk(clk), .rst_(rst_), .en(en), .fifo_empty(f_empty),
    .fifo_dout(f_dout), .fifo_rd_en(rd_en), .tx(tx),
    .busy(busy), .tx_done(done)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) u_pe (
    .clk(clk), .rst_(rst_), .en(p_en), .fifo_empty(pe_empty),
    .fifo_dout(p_dout), .fifo_rd_en(pe_rd), .tx(pe_tx),
    .busy(pe_busy), .tx_done(pe_done)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(2)
  ) u_po (
    .clk(clk), .rst_(rst_), .en(p_en), .fifo_empty(po_empty),
    .fifo_dout(p_dout), .fifo_rd_en(po_rd), .tx(po_tx),
    .busy(po_busy), .tx_done(po_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr[3:0]] = d;
    wr++;
  endtask

  function automatic logic s_rd(input int s);
    case (s)
      0:       return rd_en;
      1:       return pe_rd;
      default: return po_rd;
    endcase
  endfunction

  function automatic logic s_tx(input int s);
    case (s)
      0:       return tx;
      1:       return pe_tx;
      default: return po_tx;
    endcase
  endfunction

  function automatic logic s_busy(input int s);
    case (s)
      0:       return busy;
      1:       return pe_busy;
      default: return po_busy;
    endcase
  endfunction

  function automatic logic s_done(input int s);
    case (s)
      0:       return done;
      1:       return pe_done;
      default: return po_done;
    endcase
  endfunction

  // Per-cycle line waveform for one frame at 4 clocks per bit.
  function automatic logic [63:0] exp_tx(input logic [7:0] d,
                                         input bit pen,
                                         input bit pb,
                                         input int sb);
    logic [15:0] b;
    logic [63:0] v;
    int          nb;
    b = '0;
    v = '0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    nb = 9;
    if (pen) begin
      b[nb] = pb;
      nb++;
    end
    for (int s = 0; s < sb; s++) begin
      b[nb] = 1'b1;
      nb++;
    end
    for (int i = 0; i < nb * 4; i++) v[i] = b[i/4];
    return v;
  endfunction

  function automatic logic [15:0] mids(input logic [63:0] v,
                                       input int nb);
    logic [15:0] m;
    m = '0;
    for (int k = 0; k < nb; k++) m[k] = v[k*4+1];
    return m;
  endfunction

  task automatic wait_rd(input int s, input string tag);
    bit ok;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (s_rd(s)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Called in the read cycle: steps through LOAD, then n frame cycles.
  task automatic capture(input int s, input int n,
                         output logic [63:0] txv,
                         output logic [63:0] dv,
                         output logic ball);
    txv = '0;
    dv  = '0;
    step();
    ball = s_busy(s) & s_tx(s);
    for (int i = 0; i < n; i++) begin
      step();
      txv[i] = s_tx(s);
      dv[i]  = s_done(s);
      ball   = ball & s_busy(s);
    end
  endtask

  logic [63:0] txv, dv, txv2, dv2;
  logic        ball, ball2;
  int          base;
  bit          bad;

  initial begin
    rst_ = 1'b0;
    en   = 1'b0;
    p_en = 1'b0;
    step();
    check("rst_main", {tx, busy, done, rd_en}, 4'b1000);
    check("rst_par", {pe_tx, pe_busy, pe_done, po_tx, po_busy}, 5'b10010);
    rst_ = 1'b1;
    step();

    en  = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      step();
      if (rd_en || !tx || busy) bad = 1'b1;
    end
    check("empty_idle", 64'(bad), 64'd0);

    base = rd;
    push(8'hA5);
    wait_rd(0, "a5_rd");
    capture(0, 40, txv, dv, ball);
    check("a5_bits", mids(txv, 10), 16'h034A);
    check("a5_wave", txv, exp_tx(8'hA5, 0, 0, 1));
    check("a5_done", dv, 64'h0000_0080_0000_0000);
    check("a5_busy", 64'(ball), 64'd1);
    step();
    check("a5_idle", {busy, tx}, 2'b01);
    check("a5_rdcnt", 64'(rd - base), 64'd1);

    base = rd;
    push(8'h00);
    push(8'hFF);
    wait_rd(0, "b2b_rd0");
    capture(0, 40, txv, dv, ball);
    check("b2b_w0", txv, exp_tx(8'h00, 0, 0, 1));
    check("b2b_d0", dv, 64'h0000_0080_0000_0000);
    step();
    check("b2b_gap", {tx, rd_en, busy}, 3'b110);
    capture(0, 40, txv, dv, ball);
    check("b2b_w1", txv, exp_tx(8'hFF, 0, 0, 1));
    check("b2b_ld", 64'(ball), 64'd1);
    repeat (10) step();
    check("b2b_rdcnt", 64'(rd - base), 64'd2);
    check("b2b_empty", 64'(f_empty), 64'd1);

    p_en  = 1'b1;
    p_req = 1;
    wait_rd(1, "par_rd");
    check("par_rd_odd", 64'(po_rd), 64'd1);
    fork
      capture(1, 48, txv, dv, ball);
      capture(2, 48, txv2, dv2, ball2);
    join
    p_en = 1'b0;
    check("pe_bit", 64'(txv[37]), 64'd1);
    check("po_bit", 64'(txv2[37]), 64'd0);
    check("pe_wave", txv, exp_tx(8'h07, 1, 1, 2));
    check("po_wave", txv2, exp_tx(8'h07, 1, 0, 2));
    check("pe_done", dv, 64'h0000_8000_0000_0000);
    check("po_done", dv2, 64'h0000_8000_0000_0000);
    check("par_busy", {ball, ball2}, 2'b11);

    base = rd;
    push(8'h3C);
    push(8'h81);
    wait_rd(0, "drop_rd");
    fork
      capture(0, 40, txv, dv, ball);
      begin
        repeat (18) step();
        en = 1'b0;
      end
    join
    check("drop_wave", txv, exp_tx(8'h3C, 0, 0, 1));
    check("drop_done", dv, 64'h0000_0080_0000_0000);
    repeat (20) step();
    check("drop_rdcnt", 64'(rd - base), 64'd1);
    check("drop_left", 64'(wr - rd), 64'd1);
    check("drop_idle", {busy, tx, rd_en}, 3'b010);

    en = 1'b1;
    wait_rd(0, "rst_rd");
    repeat (12) step();
    check("rst_mid", {busy, tx}, 2'b10);
    rst_ = 1'b0;
    #1;
    check("rst_async", {tx, busy, done, rd_en}, 4'b1000);
    step();
    step();
    check("rst_hold", {tx, busy, done, rd_en}, 4'b1000);
    rst_ = 1'b1;
    push(8'h5A);
    wait_rd(0, "rec_rd");
    capture(0, 40, txv, dv, ball);
    check("rec_wave", txv, exp_tx(8'h5A, 0, 0, 1));
    check("rec_done", dv, 64'h0000_0080_0000_0000);
    step();
    check("rec_idle", {busy, tx}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
